// File: rtl/iob_ram_be_bist.sv
// iob_ram_be_bist
//   Built-in self-test initiator for one byte-enable RAM port. A start pulse
//   runs four passes over every address:
//     WR  : full-word write of P(i) = SEED + i
//     RD  : full-word read-back, compared against P(i)
//     BW  : single-byte write of 8'hFF into lane (i mod NB)
//     RD2 : read-back, compared against P(i) with that lane forced to 8'hFF
//   The first mismatch ends the run and its phase/address/expected/actual
//   words are held. The RAM port is driven only while busy; otherwise all
//   ram_* outputs are zero.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           start request, honoured only when idle or done
//   busy            a test pass is in progress
//   done, pass      run finished / finished with no mismatch
//   err_phase       1 = RD mismatch, 3 = RD2 mismatch, 0 = none
//   err_addr/exp/got  first mismatch details
//   ram_en, ram_we, ram_addr, ram_din   RAM port request
//   ram_dout        RAM read data, one cycle after a read request
`timescale 1ns/1ps

module iob_ram_be_bist #(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 4,
    parameter int unsigned SEED   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [1:0]          err_phase,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [DATA_W-1:0]   err_exp,
    output logic [DATA_W-1:0]   err_got,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout
);

    localparam int unsigned NB = DATA_W / 8;
    localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_BW   = 3'd3;
    localparam logic [2:0] S_RD2  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // The counter carries one extra bit so the read phases can reach N for
    // their trailing compare-only cycle.
    localparam logic [ADDR_W:0] I_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] I_END  = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]          r_state;
    logic [ADDR_W:0]     r_i;
    logic                r_cv;
    logic                r_done;
    logic                r_pass;
    logic [1:0]          r_err_phase;
    logic [ADDR_W-1:0]   r_err_addr;
    logic [DATA_W-1:0]   r_err_exp;
    logic [DATA_W-1:0]   r_err_got;

    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   w_cmp_addr;
    logic [DATA_W-1:0]   w_exp;
    logic                w_is_rd;
    logic                w_cmp;
    logic                w_mis;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return SEED_W + DATA_W'(a);
    endfunction

    function automatic int unsigned lane_of(input logic [ADDR_W-1:0] a);
        int unsigned v;
        v = 32'(a);
        return v % NB;
    endfunction

    function automatic logic [NB-1:0] lane_we(input logic [ADDR_W-1:0] a);
        return NB'(1) << lane_of(a);
    endfunction

    function automatic logic [DATA_W-1:0] merged(input logic [ADDR_W-1:0] a);
        return pat(a) | (DATA_W'(8'hFF) << (8 * lane_of(a)));
    endfunction

    assign w_addr     = r_i[ADDR_W-1:0];
    // Read data arriving now belongs to the request issued one cycle earlier.
    assign w_cmp_addr = w_addr - ADDR_W'(1);
    assign w_is_rd    = (r_state == S_RD) || (r_state == S_RD2);
    assign w_exp      = (r_state == S_RD) ? pat(w_cmp_addr) : merged(w_cmp_addr);
    assign w_cmp      = w_is_rd && r_cv;
    assign w_mis      = w_cmp && (ram_dout != w_exp);

    assign busy      = (r_state == S_WR) || (r_state == S_RD) ||
                       (r_state == S_BW) || (r_state == S_RD2);
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_phase = r_err_phase;
    assign err_addr  = r_err_addr;
    assign err_exp   = r_err_exp;
    assign err_got   = r_err_got;

    // Port outputs decode straight from state so an asynchronous reset
    // releases the RAM in the same instant.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = '0;
        ram_addr = '0;
        ram_din  = '0;
        case (r_state)
            S_WR: begin
                ram_en   = 1'b1;
                ram_we   = '1;
                ram_addr = w_addr;
                ram_din  = pat(w_addr);
            end
            S_RD, S_RD2: begin
                // Cycle N only compares the last word; no new request.
                if (!r_i[ADDR_W]) begin
                    ram_en   = 1'b1;
                    ram_addr = w_addr;
                end
            end
            S_BW: begin
                ram_en   = 1'b1;
                ram_we   = lane_we(w_addr);
                ram_addr = w_addr;
                ram_din  = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_cv        <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_phase <= '0;
            r_err_addr  <= '0;
            r_err_exp   <= '0;
            r_err_got   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_WR;
                        r_i         <= '0;
                        r_cv        <= 1'b0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_phase <= '0;
                        r_err_addr  <= '0;
                        r_err_exp   <= '0;
                        r_err_got   <= '0;
                    end
                end
                S_WR, S_BW: begin
                    if (r_i == I_LAST) begin
                        r_state <= (r_state == S_WR) ? S_RD : S_RD2;
                        r_i     <= '0;
                        r_cv    <= 1'b0;
                    end else begin
                        r_i <= r_i + (ADDR_W+1)'(1);
                    end
                end
                S_RD, S_RD2: begin
                    if (w_mis) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_phase <= (r_state == S_RD) ? 2'd1 : 2'd3;
                        r_err_addr  <= w_cmp_addr;
                        r_err_exp   <= w_exp;
                        r_err_got   <= ram_dout;
                    end else if (r_i == I_END) begin
                        r_i  <= '0;
                        r_cv <= 1'b0;
                        if (r_state == S_RD) begin
                            r_state <= S_BW;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end
                    end else begin
                        r_i  <= r_i + (ADDR_W+1)'(1);
                        r_cv <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_ram_be_bist.sv
`timescale 1ns/1ps

module tb_iob_ram_be_bist;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 4;
    localparam int          N      = 16;
    localparam int          NB     = 4;
    localparam int unsigned SEED   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done, pass;
    logic [1:0]        err_phase;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_exp, err_got;
    logic              ram_en;
    logic [NB-1:0]     ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] rdata;

    // RAM model state and fault knobs
    logic [31:0] mem [0:N-1];
    logic [31:0] nw;
    logic        fill;
    logic        stuck_en, stuck_val, ign;
    logic [3:0]  stuck_addr;
    logic [4:0]  stuck_bit;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iob_ram_be_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .err_phase(err_phase), .err_addr(err_addr),
        .err_exp(err_exp), .err_got(err_got),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(rdata)
    );

    function automatic logic [31:0] faulty(input logic [3:0] a, input logic [31:0] w);
        logic [31:0] r;
        r = w;
        if (stuck_en && a == stuck_addr) r[stuck_bit] = stuck_val;
        return r;
    endfunction

    function automatic logic [31:0] pat(input int j);
        return SEED + 32'(j);
    endfunction

    function automatic logic [31:0] qpat(input int j);
        logic [31:0] p;
        p = pat(j);
        case (j % NB)
            0: p[7:0]   = 8'hFF;
            1: p[15:8]  = 8'hFF;
            2: p[23:16] = 8'hFF;
            default: p[31:24] = 8'hFF;
        endcase
        return p;
    endfunction

    // One-cycle-latency byte-enable RAM with optional faults.
    always @(posedge clk) begin
        if (fill) begin
            for (int k = 0; k < N; k++) mem[k] <= 32'hDEAD_BEEF;
        end else if (ram_en) begin
            if (ram_we != 0) begin
                nw = mem[ram_addr];
                for (int b = 0; b < NB; b++)
                    if (ram_we[b] || ign) nw[8*b +: 8] = ram_din[8*b +: 8];
                mem[ram_addr] <= nw;
            end else begin
                rdata <= faulty(ram_addr, mem[ram_addr]);
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_ctl"}, 64'({busy, done, pass, err_phase, err_addr, ram_en, ram_we, ram_addr}), 64'd0);
        check_val({tag, "_exp"}, 64'(err_exp), 64'd0);
        check_val({tag, "_got"}, 64'(err_got), 64'd0);
        check_val({tag, "_din"}, 64'(ram_din), 64'd0);
    endtask

    // Phase-level outcome of one run for the current fault setting.
    task automatic ref_model(output logic p, output logic [1:0] ph, output logic [3:0] ad,
                             output logic [31:0] ex, output logic [31:0] gt, output int cyc);
        logic [31:0] m [N];
        logic [31:0] g;
        p = 1'b1; ph = 2'd0; ad = 4'd0; ex = 32'd0; gt = 32'd0; cyc = 4*N + 2;
        for (int j = 0; j < N; j++) m[j] = pat(j);
        for (int j = 0; j < N; j++) begin
            g = faulty(4'(j), m[j]);
            if (g != pat(j)) begin
                p = 1'b0; ph = 2'd1; ad = 4'(j); ex = pat(j); gt = g; cyc = N + j + 2;
                return;
            end
        end
        for (int j = 0; j < N; j++) m[j] = ign ? 32'hFFFF_FFFF : qpat(j);
        for (int j = 0; j < N; j++) begin
            g = faulty(4'(j), m[j]);
            if (g != qpat(j)) begin
                p = 1'b0; ph = 2'd3; ad = 4'(j); ex = qpat(j); gt = g; cyc = 3*N + j + 3;
                return;
            end
        end
    endtask

    // Start a run and return the number of edges from the start edge to done.
    task automatic do_run(input logic hold_start, output int edges);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        check_val("run_busy_e0", 64'(busy), 64'd1);
        check_val("run_done_clr", 64'(done), 64'd0);
        edges = 0;
        while (!done && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        if (!done) check_val("run_timeout", 64'(edges), 64'd0);
    endtask

    task automatic no_access(input string tag);
        int acc;
        acc = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_en || ram_we != 0) acc++;
        end
        check_val(tag, 64'(acc), 64'd0);
    endtask

    int          e, k;
    logic        m_p;
    logic [1:0]  m_ph;
    logic [3:0]  m_ad;
    logic [31:0] m_ex, m_gt;
    int          m_cyc;

    initial begin
        rst = 1'b1; start = 1'b0; fill = 1'b0;
        stuck_en = 1'b0; stuck_val = 1'b0; ign = 1'b0;
        stuck_addr = 4'd0; stuck_bit = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_init");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        // Good RAM
        do_run(1'b0, e);
        check_val("good_latency", 64'(e), 64'd66);
        check_val("good_pass", 64'({done, pass, busy}), 64'b110);
        check_val("good_phase", 64'(err_phase), 64'd0);
        check_val("good_mem5", 64'(mem[5]), 64'h0000_FF25);
        check_val("good_mem0", 64'(mem[0]), 64'h0000_00FF);
        repeat (3) @(posedge clk);
        #1;
        check_val("good_hold", 64'({done, pass, ram_en}), 64'b110);

        // Stuck-at-0 on bit 0 of word 9
        stuck_en = 1'b1; stuck_addr = 4'd9; stuck_bit = 5'd0; stuck_val = 1'b0;
        do_run(1'b0, e);
        check_val("stuck_lat", 64'(e), 64'(N + 9 + 2));
        check_val("stuck_pass", 64'({done, pass}), 64'b10);
        check_val("stuck_phase", 64'(err_phase), 64'd1);
        check_val("stuck_addr", 64'(err_addr), 64'd9);
        check_val("stuck_exp", 64'(err_exp), 64'h29);
        check_val("stuck_got", 64'(err_got), 64'h28);
        no_access("stuck_noacc");
        stuck_en = 1'b0;

        // Reset pulse while holding error results
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("rst_pulse");
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_idle");

        // RAM ignoring byte enables
        ign = 1'b1;
        do_run(1'b0, e);
        check_val("ign_pass", 64'({done, pass}), 64'b10);
        check_val("ign_phase", 64'(err_phase), 64'd3);
        check_val("ign_addr", 64'(err_addr), 64'd0);
        check_val("ign_exp", 64'(err_exp), 64'h0000_00FF);
        check_val("ign_got", 64'(err_got), 64'hFFFF_FFFF);
        ign = 1'b0;

        // Reset during WR at i=7
        @(negedge clk) fill = 1'b1;
        @(negedge clk) fill = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (!(ram_we != 0 && ram_addr == 4'd7) && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_val("wr7_reach", 64'(k), 64'd7);
        #2 rst = 1'b1;
        #1;
        check_val("wr7_abort", 64'({ram_en, busy}), 64'd0);
        @(negedge clk) rst = 1'b0;
        check_val("wr7_mem6", 64'(mem[6]), 64'(pat(6)));
        check_val("wr7_mem8", 64'(mem[8]), 64'hDEAD_BEEF);
        check_val("wr7_mem15", 64'(mem[15]), 64'hDEAD_BEEF);
        do_run(1'b0, e);
        check_val("wr7_rerun", 64'({e[7:0], done, pass}), 64'({8'd66, 2'b11}));

        // Start held high, then restart from DONE
        do_run(1'b1, e);
        check_val("hold_run", 64'({e[7:0], done, pass}), 64'({8'd66, 2'b11}));
        do_run(1'b0, e);
        check_val("restart_run", 64'({e[7:0], done, pass}), 64'({8'd66, 2'b11}));

        // Randomized fault configurations against the phase-level model
        for (int t = 0; t < 10; t++) begin
            stuck_en   = 1'($urandom_range(0, 1));
            stuck_addr = 4'($urandom_range(0, 15));
            stuck_bit  = 5'($urandom_range(0, 31));
            stuck_val  = 1'($urandom_range(0, 1));
            ign        = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            do_run(1'b0, e);
            ref_model(m_p, m_ph, m_ad, m_ex, m_gt, m_cyc);
            check_val("rnd_latency", 64'(e), 64'(m_cyc));
            check_val("rnd_pass", 64'({done, pass}), 64'({1'b1, m_p}));
            check_val("rnd_phase", 64'({err_phase, err_addr}), 64'({m_ph, m_ad}));
            check_val("rnd_exp", 64'(err_exp), 64'(m_ex));
            check_val("rnd_got", 64'(err_got), 64'(m_gt));
        end
        stuck_en = 1'b0;
        ign = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
